// File: rtl/peripheral_bcd2bin.sv
// rtl/peripheral_bcd2bin.sv - memory-mapped packed-BCD to binary converter
// Bus registers and read data update on the falling edge; the conversion FSM runs on the rising edge.
module peripheral_bcd2bin #(
  parameter int NDIG = 5,
  parameter int NBIN = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NBIN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    bcd;
  logic            init;
  logic [W-1:0]    sr;
  logic [NBIN-1:0] bin;
  logic [CW-1:0]   cnt;
  logic [NBIN-1:0] result;
  logic            done;
  logic            err;

  logic            sel_bcd, sel_init, sel_result, sel_done, sel_err;
  logic            rd_hit;
  logic [31:0]     rd_mux;
  logic [W-1:0]    sr_fixed;
  logic [NBIN-1:0] bin_next;
  logic            bad_digit;
  logic            unused_bits;

  // rd is informational only; reads are selected by cs and addr
  assign unused_bits = ^{rd, d_in[31:W]};

  assign sel_bcd    = cs && (addr == 5'h04);
  assign sel_init   = cs && (addr == 5'h0C);
  assign sel_result = cs && (addr == 5'h10);
  assign sel_done   = cs && (addr == 5'h14);
  assign sel_err    = cs && (addr == 5'h18);
  assign rd_hit     = sel_bcd || sel_result || sel_done || sel_err;

  always_comb begin
    rd_mux = 32'd0;
    if (sel_bcd)    rd_mux = {{(32-W){1'b0}}, bcd};
    if (sel_result) rd_mux = {{(32-NBIN){1'b0}}, result};
    if (sel_done)   rd_mux = {31'd0, done};
    if (sel_err)    rd_mux = {31'd0, err};
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      bcd   <= '0;
      init  <= 1'b0;
      d_out <= 32'd0;
    end else begin
      if (sel_bcd && wr)  bcd  <= d_in[W-1:0];
      if (sel_init && wr) init <= d_in[0];
      if (rd_hit)         d_out <= rd_mux;
    end
  end

  // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3
  always_comb begin
    logic [W-1:0] shifted;
    logic [3:0]   nib;
    shifted  = sr >> 1;
    sr_fixed = shifted;
    for (int i = 0; i < NDIG; i++) begin
      nib = shifted[4*i +: 4];
      if (nib >= 4'd8) sr_fixed[4*i +: 4] = nib - 4'd3;
    end
    bin_next = {sr[0], bin[NBIN-1:1]};
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      bin    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (init) begin
            sr  <= bcd;
            bin <= '0;
            cnt <= '0;
            if (bad_digit) begin
              err    <= 1'b1;
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              err   <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sr  <= sr_fixed;
          bin <= bin_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NBIN - 1)) begin
            result <= bin_next;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (!init) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bcd2bin.sv
// tb/tb_peripheral_bcd2bin.sv - directed bench for peripheral_bcd2bin
// Inputs change 1 ns after the rising edge so the falling-edge bus logic samples them cleanly.
module tb_peripheral_bcd2bin;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  int errors = 0;
  int checks = 0;

  peripheral_bcd2bin dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] v, input logic sel = 1'b1);
    @(posedge clk); #1;
    cs = sel; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v, input logic sel = 1'b1);
    @(posedge clk); #1;
    cs = sel; rd = 1'b1; addr = a;
    @(negedge clk); #1;
    v = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  // Counts rising edges after init=1 was written until done is high
  task automatic wait_done(output int lat);
    lat = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      lat++;
      if (dut.done) break;
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] operand, input logic [31:0] exp_res,
                         input int exp_lat, input logic [31:0] exp_err);
    logic [31:0] v;
    int lat;
    bus_write(5'h04, operand);
    bus_write(5'h0C, 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    bus_read(5'h14, v); check({tag, " done"}, v, 32'd1);
    bus_read(5'h10, v); check({tag, " result"}, v, exp_res);
    bus_read(5'h18, v); check({tag, " err"}, v, exp_err);
    bus_write(5'h0C, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    int lat;
    reset = 1'b1; d_in = '0; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset d_out", d_out, 32'd0);
    reset = 1'b0;
    bus_read(5'h04, v); check("reset bcd", v, 32'd0);
    bus_read(5'h10, v); check("reset result", v, 32'd0);
    bus_read(5'h14, v); check("reset done", v, 32'd0);
    bus_read(5'h18, v); check("reset err", v, 32'd0);

    convert("c12345", 32'h12345, 32'h00003039, 18, 32'd0);
    bus_read(5'h14, v); check("done cleared", v, 32'd0);
    convert("c99999", 32'h99999, 32'h0001869F, 18, 32'd0);
    convert("c00000", 32'h00000, 32'h00000000, 18, 32'd0);
    convert("c00001", 32'h00001, 32'h00000001, 18, 32'd0);
    convert("c0A123", 32'h0A123, 32'h00000000, 1, 32'd1);
    convert("c00042", 32'h00042, 32'h0000002A, 18, 32'd0);

    // Operand and init writes during SHIFT must not disturb the running conversion
    bus_write(5'h04, 32'h12345);
    bus_write(5'h0C, 32'd1);
    bus_write(5'h04, 32'h00007);
    bus_write(5'h0C, 32'd1);
    wait_done(lat);
    check("iso latency", 32'(lat + 2), 32'd18);
    bus_read(5'h10, v); check("iso result", v, 32'h00003039);
    bus_read(5'h04, v); check("iso bcd reg", v, 32'h00007);
    bus_write(5'h0C, 32'd0);
    bus_write(5'h0C, 32'd1);
    wait_done(lat);
    check("iso2 latency", 32'(lat), 32'd18);
    bus_read(5'h10, v); check("iso2 result", v, 32'h00000007);
    bus_write(5'h0C, 32'd0);

    // Reset in the middle of a conversion
    bus_write(5'h04, 32'h12345);
    bus_write(5'h0C, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst done", 32'(dut.done), 32'd0);
    check("rst d_out", d_out, 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst no late done", 32'(dut.done), 32'd0);
    bus_read(5'h10, v); check("rst result", v, 32'd0);
    bus_read(5'h14, v); check("rst done rd", v, 32'd0);
    convert("c54321", 32'h54321, 32'h0000D431, 18, 32'd0);

    // Hold behaviour for unmapped reads and deselected accesses
    bus_read(5'h10, v); check("hold load", v, 32'h0000D431);
    bus_read(5'h1C, v); check("hold unmapped", v, 32'h0000D431);
    bus_read(5'h14, v, 1'b0); check("hold cs0", v, 32'h0000D431);
    bus_write(5'h04, 32'h11111, 1'b0);
    bus_write(5'h0C, 32'd1, 1'b0);
    repeat (3) @(posedge clk);
    bus_read(5'h04, v); check("cs0 bcd", v, 32'h54321);
    bus_read(5'h14, v); check("cs0 init", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
